// File: rtl/ram_port_b_client.sv
// rtl/ram_port_b_client.sv - port B initiator: fill sweep plus credited streaming reads
//
// Ports:
//   clock, reset_n            single clock, asynchronous active-low reset
//   clear_req, fill_data      start a fill sweep writing fill_data to every address
//   clear_busy, clear_done    sweep in progress / one-cycle pulse after the last write
//   req_valid/ready, req_addr read request channel
//   rsp_valid/ready, rsp_data read response channel (in request order)
//   ram_enable, ram_wren,     registered port B controls
//   ram_address, ram_data
//   ram_q                     port B read data, one clock after an enabled read

module ram_port_b_client #(
  parameter int addr_width_g = 11,
  parameter int data_width_g = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear_req,
  input  logic [data_width_g-1:0] fill_data,
  output logic                    clear_busy,
  output logic                    clear_done,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [addr_width_g-1:0] req_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [data_width_g-1:0] rsp_data,
  output logic                    ram_enable,
  output logic                    ram_wren,
  output logic [addr_width_g-1:0] ram_address,
  output logic [data_width_g-1:0] ram_data,
  input  logic [data_width_g-1:0] ram_q
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [addr_width_g-1:0] last_addr = '1;

  state_t                  state, state_d;
  logic [addr_width_g-1:0] sweep_cnt, sweep_cnt_d;
  logic [data_width_g-1:0] fill_reg, fill_reg_d;
  logic                    done_d;
  logic                    en_d, wren_d;
  logic [addr_width_g-1:0] addr_d;
  logic [data_width_g-1:0] wdata_d;

  // tag_issue: a read is on the port this cycle; tag_data: ram_q holds read data now
  logic                    tag_issue, tag_data;
  logic [data_width_g-1:0] fifo_mem [4];
  logic [1:0]              wr_ptr, rd_ptr;
  logic [2:0]              fifo_count;
  logic [2:0]              in_flight;
  logic                    accept, push, pop;

  // Every issued read owns a FIFO slot until it is popped, so 4 credits cannot overflow.
  assign in_flight  = fifo_count + {2'b00, tag_issue} + {2'b00, tag_data};
  assign req_ready  = (state == IDLE) && !clear_req && (in_flight < 3'd4);
  assign accept     = req_valid && req_ready;
  assign push       = tag_data;
  assign pop        = rsp_valid && rsp_ready;
  assign rsp_valid  = (fifo_count != 3'd0);
  assign rsp_data   = fifo_mem[rd_ptr];
  assign clear_busy = (state == CLEAR);

  // sweep_cnt always equals the address of the sweep write currently on the port
  always_comb begin
    state_d     = state;
    sweep_cnt_d = sweep_cnt;
    fill_reg_d  = fill_reg;
    done_d      = 1'b0;
    en_d        = 1'b0;
    wren_d      = 1'b0;
    addr_d      = ram_address;
    wdata_d     = ram_data;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_d     = CLEAR;
          sweep_cnt_d = '0;
          fill_reg_d  = fill_data;
          en_d        = 1'b1;
          wren_d      = 1'b1;
          addr_d      = '0;
          wdata_d     = fill_data;
        end else if (accept) begin
          en_d   = 1'b1;
          addr_d = req_addr;
        end
      end
      CLEAR: begin
        if (sweep_cnt == last_addr) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          sweep_cnt_d = sweep_cnt + addr_width_g'(1);
          en_d        = 1'b1;
          wren_d      = 1'b1;
          addr_d      = sweep_cnt + addr_width_g'(1);
          wdata_d     = fill_reg;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sweep_cnt   <= '0;
      fill_reg    <= '0;
      clear_done  <= 1'b0;
      ram_enable  <= 1'b0;
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      tag_issue   <= 1'b0;
      tag_data    <= 1'b0;
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      fifo_count  <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      state       <= state_d;
      sweep_cnt   <= sweep_cnt_d;
      fill_reg    <= fill_reg_d;
      clear_done  <= done_d;
      ram_enable  <= en_d;
      ram_wren    <= wren_d;
      ram_address <= addr_d;
      ram_data    <= wdata_d;
      tag_issue   <= accept;
      tag_data    <= tag_issue;
      if (push) begin
        fifo_mem[wr_ptr] <= ram_q;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_b_client.sv
// tb/tb_ram_port_b_client.sv - randomized scoreboard bench for ram_port_b_client

module tb_ram_port_b_client;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       clear_req;
  logic [7:0] fill_data;
  logic       clear_busy, clear_done;
  logic       req_valid, req_ready;
  logic [3:0] req_addr;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       ram_enable, ram_wren;
  logic [3:0] ram_address;
  logic [7:0] ram_data;
  logic [7:0] ram_q;

  int tests, fails;
  int cyc, acc_cnt, pop_cnt, busy_cnt, done_cnt, sweep_idx, first_acc_edge, first_rv;
  logic       acc_prev;
  logic [3:0] prev_addr;
  logic [7:0] ram [16];
  logic [7:0] model [16];
  logic [7:0] cur_fill, sweep_fill;
  logic [7:0] exp_q [$];

  ram_port_b_client #(.addr_width_g(4), .data_width_g(8)) dut (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .fill_data(fill_data),
    .clear_busy(clear_busy), .clear_done(clear_done), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .ram_enable(ram_enable),
    .ram_wren(ram_wren), .ram_address(ram_address), .ram_data(ram_data), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Synchronous RAM: write on enable+wren, registered read data otherwise
  task automatic ram_model();
    forever begin
      @(posedge clock);
      cyc++;
      if (ram_enable) begin
        if (ram_wren) ram[ram_address] = ram_data;
        else          ram_q <= ram[ram_address];
      end
    end
  endtask

  // Expected responses are the bench's view of RAM contents at accept time.
  task automatic monitor();
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        exp_q.delete();
        sweep_idx = 0;
        acc_prev  = 1'b0;
      end else begin
        check_eq("port_wren", ram_wren, clear_busy);
        check_eq("port_en", ram_enable, clear_busy | acc_prev);
        if (!clear_busy && acc_prev) check_eq("port_raddr", ram_address, prev_addr);
        if (clear_busy) begin
          if (sweep_idx == 0) sweep_fill = cur_fill;
          check_eq("sweep_write", {ram_enable, ram_wren, ram_address, ram_data},
                   {2'b11, 4'(sweep_idx), sweep_fill});
          sweep_idx++;
          busy_cnt++;
        end
        if (clear_done) begin
          done_cnt++;
          check_eq("done_busy_low", clear_busy, 0);
          check_eq("sweep_len", sweep_idx, 16);
          for (int i = 0; i < 16; i++) model[i] = sweep_fill;
          sweep_idx = 0;
        end
        if (rsp_valid && first_rv < 0) first_rv = cyc;
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) check_eq("rsp_extra", rsp_valid, 0);
          else check_eq("rsp_data", rsp_data, exp_q.pop_front());
          pop_cnt++;
        end
        acc_prev = req_valid && req_ready;
        if (acc_prev) begin
          exp_q.push_back(model[req_addr]);
          prev_addr = req_addr;
          acc_cnt++;
          if (first_acc_edge < 0) first_acc_edge = cyc + 1;
        end
      end
    end
  endtask

  task automatic issue_read(input int addr, output bit ok);
    int n;
    req_valid = 1'b1;
    req_addr  = 4'(addr);
    ok = 1'b0;
    n  = 0;
    while (n < 50) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_eq(tag, (n < 100), 1);
  endtask

  initial begin
    bit   ok;
    int   n, a0, p0, c0, b0, d0;
    logic en_seen, v_seen;
    tests = 0; fails = 0; cyc = 0; acc_cnt = 0; pop_cnt = 0; busy_cnt = 0; done_cnt = 0;
    sweep_idx = 0; first_acc_edge = -1; first_rv = -1; acc_prev = 1'b0; prev_addr = '0;
    cur_fill = '0; sweep_fill = '0; ram_q = '0;
    reset_n = 1'b0; clear_req = 1'b0; fill_data = '0; req_valid = 1'b0; req_addr = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ram[i]   = 8'(i);
      model[i] = 8'(i);
    end
    fork
      ram_model();
      monitor();
    join_none

    // reset and idle
    tick(3);
    @(negedge clock);
    check_eq("rst_outputs", {clear_busy, clear_done, rsp_valid, rsp_data, ram_enable,
                             ram_wren, ram_address, ram_data}, 0);
    reset_n = 1'b1;
    en_seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      en_seen |= ram_enable;
    end
    check_eq("idle_enable", en_seen, 0);
    check_eq("idle_outputs", {clear_busy, clear_done, rsp_valid, ram_wren, ram_address}, 0);
    check_eq("idle_req_ready", req_ready, 1);

    // streaming: 16 back-to-back reads, data == address
    tick(1);
    rsp_ready = 1'b1;
    first_acc_edge = -1; first_rv = -1;
    p0 = pop_cnt; c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      issue_read(i, ok);
      check_eq("stream_accept", ok, 1);
    end
    check_eq("stream_cycles", cyc - c0, 16);
    wait_drain("stream_drain");
    check_eq("stream_latency", first_rv - first_acc_edge, 2);
    check_eq("stream_count", pop_cnt - p0, 16);

    // backpressure: 4 credits, then drain and resume
    tick(1);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 4'($urandom_range(0, 15));
    a0 = acc_cnt;
    tick(10);
    @(negedge clock);
    check_eq("bp_accepts", acc_cnt - a0, 4);
    check_eq("bp_ready_low", req_ready, 0);
    check_eq("bp_rsp_valid", rsp_valid, 1);
    @(posedge clock);
    #1;
    rsp_ready = 1'b1;
    repeat (12) begin
      tick(1);
      req_addr = 4'($urandom_range(0, 15));
    end
    req_valid = 1'b0;
    wait_drain("bp_drain");
    check_eq("bp_balance", acc_cnt, pop_cnt);

    // sweep with 0xA5, second clear_req mid-sweep must be ignored
    tick(1);
    b0 = busy_cnt; d0 = done_cnt;
    clear_req = 1'b1; fill_data = 8'hA5; cur_fill = 8'hA5;
    tick(1);
    clear_req = 1'b0; fill_data = 8'h5A;
    tick(4);
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    tick(5);
    check_eq("sweep_busy_cycles", busy_cnt - b0, 16);
    check_eq("sweep_done_pulses", done_cnt - d0, 1);
    issue_read(7, ok);
    check_eq("read7_accept", ok, 1);
    wait_drain("read7_drain");

    // collision: read accepted one cycle before clear_req, then read blocked by clear
    tick(1);
    issue_read(5, ok);
    check_eq("coll_first_accept", ok, 1);
    clear_req = 1'b1; fill_data = 8'h3C; cur_fill = 8'h3C;
    req_valid = 1'b1; req_addr = 4'd6;
    @(negedge clock);
    check_eq("coll_ready_low", req_ready, 0);
    check_eq("coll_port_read", {ram_enable, ram_wren, ram_address}, {2'b10, 4'd5});
    @(posedge clock);
    #1;
    clear_req = 1'b0;
    ok = 1'b0; n = 0;
    while (n < 40) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    check_eq("coll_ready_at_done", {ok, clear_done}, 2'b11);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    wait_drain("coll_drain");

    // randomized traffic with occasional sweeps
    tick(1);
    repeat (400) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      fill_data = 8'($urandom);
      clear_req = 1'b0;
      if (!clear_busy && $urandom_range(0, 39) == 0) begin
        clear_req = 1'b1;
        cur_fill  = fill_data;
      end
      tick(1);
    end
    clear_req = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    n = 0;
    while (clear_busy && n < 40) begin
      @(negedge clock);
      n++;
    end
    wait_drain("rand_drain");
    check_eq("rand_balance", acc_cnt, pop_cnt);

    // reset at sweep address 9 with responses parked in the FIFO
    tick(1);
    rsp_ready = 1'b0;
    issue_read(1, ok);
    issue_read(2, ok);
    clear_req = 1'b1; fill_data = 8'h11; cur_fill = 8'h11;
    tick(1);
    clear_req = 1'b0;
    d0 = done_cnt;
    n = 0;
    while (!(clear_busy && ram_address == 4'd9) && n < 40) begin
      @(negedge clock);
      n++;
    end
    check_eq("rst_sweep_at9", {clear_busy, ram_address}, {1'b1, 4'd9});
    check_eq("rst_fifo_loaded", rsp_valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("rst_abort_outputs", {clear_busy, rsp_valid, ram_enable, ram_wren, clear_done}, 0);
    tick(2);
    reset_n = 1'b1;
    v_seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      v_seen |= rsp_valid | clear_done | clear_busy;
    end
    check_eq("rst_quiet_after", v_seen, 0);
    check_eq("rst_no_done", done_cnt - d0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
